// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU rounding-mode encodings, fflags bit positions and sequencer states
package fpu_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} seq_state_e;
  function automatic logic [4:0] pack_fflags(input logic nv, input logic of, input logic uf, input logic nx);
    logic [4:0] f;
    f = '0;
    f[FF_NV] = nv;
    f[FF_OF] = of;
    f[FF_UF] = uf;
    f[FF_NX] = nx;
    return f;
  endfunction
endpackage

// File: rtl/fpu_rm_resolve.sv
// fpu_rm_resolve: substitutes frm for a dynamic rm and flags reserved encodings
module fpu_rm_resolve
  import fpu_pkg::*;
(
  input  logic [2:0] req_rm,
  input  logic [2:0] frm,
  output logic [2:0] rm,
  output logic       illegal
);
  always_comb begin
    rm      = (req_rm == RM_DYN) ? frm : req_rm;
    illegal = rm > RM_RMM;
  end
endmodule

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: issue/collect sequencer between FP decode, SP_Multiplier and writeback
module fpu_mul_seq
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [2:0]       frm,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [2:0]       mul_rm,
  input  logic [31:0]      mul_result,
  input  logic             mul_flag_invalid,
  input  logic             mul_flag_overflow,
  input  logic             mul_flag_underflow,
  input  logic             mul_flag_inexact,
  input  logic             mul_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_fflags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             busy
);
  seq_state_e       state_q, state_d;
  logic [2:0]       rm_res;
  logic             rm_ill, accept, capture;
  logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d, rsp_result_q, rsp_result_d;
  logic [2:0]       mul_rm_q, mul_rm_d;
  logic [4:0]       rsp_fflags_q, rsp_fflags_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  fpu_rm_resolve u_rm (
    .req_rm (req_rm),
    .frm    (frm),
    .rm     (rm_res),
    .illegal(rm_ill)
  );

  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;

  // The multiplier cannot be aborted, so a flush before done parks in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? (rm_ill ? S_RESP : S_ISSUE) : S_IDLE;
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT:  state_d = mul_done ? (flush ? S_IDLE : S_RESP) : (flush ? S_DRAIN : S_WAIT);
      S_RESP:  state_d = (flush || rsp_ready) ? S_IDLE : S_RESP;
      S_DRAIN: state_d = mul_done ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && !flush;
    mul_start = state_q == S_ISSUE;
    rsp_valid = state_q == S_RESP;
    busy      = state_q != S_IDLE;
  end

  always_comb begin
    accept        = req_valid && req_ready;
    capture       = (state_q == S_WAIT) && mul_done && !flush;
    mul_a_d       = accept ? req_a : mul_a_q;
    mul_b_d       = accept ? req_b : mul_b_q;
    mul_rm_d      = accept ? rm_res : mul_rm_q;
    rsp_tag_d     = accept ? req_tag : rsp_tag_q;
    rsp_illegal_d = accept ? rm_ill : rsp_illegal_q;
    rsp_result_d  = accept ? '0 : capture ? mul_result : rsp_result_q;
    rsp_fflags_d  = accept ? '0 : capture ? pack_fflags(mul_flag_invalid, mul_flag_overflow,
                                                         mul_flag_underflow, mul_flag_inexact)
                                          : rsp_fflags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_rm_q      <= '0;
      rsp_result_q  <= '0;
      rsp_fflags_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_rm_q      <= mul_rm_d;
      rsp_result_q  <= rsp_result_d;
      rsp_fflags_q  <= rsp_fflags_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_rm      = mul_rm_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_fflags  = rsp_fflags_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_fpu_mul_seq.sv
// tb_fpu_mul_seq: scenario tasks against a behavioural multiplier stub and response model
module tb_fpu_mul_seq;
  localparam int TAG_W = 5;
  logic             clk = 1'b0;
  logic             rst, flush, req_valid, rsp_ready;
  logic [2:0]       frm, req_rm;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready, mul_start, rsp_valid, rsp_illegal, busy;
  logic [31:0]      mul_a, mul_b, rsp_result;
  logic [2:0]       mul_rm;
  logic [4:0]       rsp_fflags;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      mul_result = '0;
  logic             mul_flag_invalid = 1'b0, mul_flag_overflow = 1'b0;
  logic             mul_flag_underflow = 1'b0, mul_flag_inexact = 1'b0, mul_done = 1'b0;
  int               n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fpu_mul_seq #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .frm(frm),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_rm(req_rm), .req_tag(req_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_result(mul_result), .mul_flag_invalid(mul_flag_invalid),
    .mul_flag_overflow(mul_flag_overflow), .mul_flag_underflow(mul_flag_underflow),
    .mul_flag_inexact(mul_flag_inexact), .mul_done(mul_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_fflags(rsp_fflags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  // Multiplier stub: known products for the directed cases, random otherwise
  logic        m_busy = 1'b0;
  int          m_cnt = 0, starts = 0, next_lat = 2;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_rm = '0;
  logic [3:0]  m_fl = '0;
  logic [4:0]  m_flg = '0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    mul_result <= $urandom;
    {mul_flag_invalid, mul_flag_overflow, mul_flag_underflow, mul_flag_inexact} <= 4'($urandom);
    if (rst) m_busy = 1'b0;
    else begin
      if (m_busy) begin
        n_checks++;
        if (mul_a !== m_a || mul_b !== m_b || mul_rm !== m_rm) begin
          n_fail++;
          $display("FAIL operand_hold: a=%h b=%h rm=%0d required a=%h b=%h rm=%0d", mul_a, mul_b, mul_rm, m_a, m_b, m_rm);
        end
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          mul_done <= 1'b1;
          mul_result <= m_res;
          {mul_flag_invalid, mul_flag_overflow, mul_flag_underflow, mul_flag_inexact} <= m_fl;
        end
      end
      if (mul_start) begin
        starts++;
        n_checks++;
        if (m_busy) begin
          n_fail++;
          $display("FAIL start_while_busy: start=1 required 0");
        end
        m_busy = 1'b1;
        m_a = mul_a;
        m_b = mul_b;
        m_rm = mul_rm;
        m_cnt = next_lat;
        case ({mul_a, mul_b})
          64'h40000000_40400000: begin m_res = 32'h40C00000; m_fl = 4'b0000; end
          64'h7F800000_00000000: begin m_res = 32'h7FC00000; m_fl = 4'b1000; end
          64'h3F800000_3F800000: begin m_res = 32'h3F800000; m_fl = 4'b0000; end
          default:               begin m_res = $urandom;     m_fl = 4'($urandom); end
        endcase
        m_flg = {m_fl[3], 1'b0, m_fl[2:0]};
      end
    end
  end

  task automatic send(input logic [31:0] a, b, input logic [2:0] rm, fr, input logic [TAG_W-1:0] tag, input int lat);
    next_lat = lat;
    req_a = a;
    req_b = b;
    req_rm = rm;
    frm = fr;
    req_tag = tag;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output bit saw_v);
    cyc = 0;
    saw_v = 0;
    while (busy !== 1'b0 && cyc < 40) begin
      @(negedge clk);
      saw_v |= (rsp_valid === 1'b1);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [2:0] rm, fr, input logic [TAG_W-1:0] tag,
                        input int lat, hold, output logic [31:0] res, output logic [4:0] ff);
    int s0, cnt;
    logic [2:0] rr;
    bit ill;
    logic [31:0] r0;
    logic [4:0] f0;
    logic [TAG_W-1:0] t0;
    logic i0;
    s0 = starts;
    rr = (rm == 3'b111) ? fr : rm;
    ill = rr >= 3'd5;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL req_ready_idle: got %b required 1", req_ready); end
    send(a, b, rm, fr, tag, lat);
    if (ill) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== 32'h0 || rsp_fflags !== 5'h0 || starts != s0) begin
        n_fail++;
        $display("FAIL illegal_rsp: valid=%b illegal=%b result=%h fflags=%b starts=%0d required 1 1 0 0 %0d", rsp_valid, rsp_illegal, rsp_result, rsp_fflags, starts, s0);
      end
    end else begin
      cnt = 0;
      while (rsp_valid !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
      n_checks++;
      if (cnt >= 40) begin n_fail++; $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", cnt); end
      n_checks++;
      if (starts != s0 + 1 || m_rm !== rr || m_a !== a || m_b !== b) begin
        n_fail++;
        $display("FAIL issue: starts=%0d rm=%0d a=%h b=%h required %0d %0d %h %h", starts - s0, m_rm, m_a, m_b, 1, rr, a, b);
      end
      n_checks++;
      if (rsp_result !== m_res || rsp_fflags !== m_flg || rsp_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_data: result=%h fflags=%b illegal=%b required %h %b 0", rsp_result, rsp_fflags, rsp_illegal, m_res, m_flg);
      end
    end
    n_checks++;
    if (rsp_tag !== tag) begin n_fail++; $display("FAIL rsp_tag: got %0d required %0d", rsp_tag, tag); end
    res = rsp_result;
    ff = rsp_fflags;
    r0 = rsp_result;
    f0 = rsp_fflags;
    t0 = rsp_tag;
    i0 = rsp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== r0 || rsp_fflags !== f0 || rsp_tag !== t0 || rsp_illegal !== i0) begin
        n_fail++;
        $display("FAIL stall_stable: valid=%b ready=%b result=%h fflags=%b tag=%0d required 1 0 %h %b %0d", rsp_valid, req_ready, rsp_result, rsp_fflags, rsp_tag, r0, f0, t0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (rsp_valid !== 1'b0 || mul_start !== 1'b0 || busy !== 1'b0 || rsp_result !== 32'h0 || rsp_fflags !== 5'h0 ||
        rsp_tag !== '0 || rsp_illegal !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 || mul_rm !== 3'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b start=%b busy=%b result=%h mul_a=%h required all zero", rsp_valid, mul_start, busy, rsp_result, mul_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_normal();
    logic [31:0] r;
    logic [4:0] f;
    run_op(32'h40000000, 32'h40400000, 3'b000, 3'b000, 5'd3, 6, 0, r, f);
    n_checks++;
    if (r !== 32'h40C00000 || f !== 5'b00000) begin n_fail++; $display("FAIL normal_mul: result=%h fflags=%b required 40c00000 00000", r, f); end
  endtask

  task automatic test_invalid();
    logic [31:0] r;
    logic [4:0] f;
    run_op(32'h7F800000, 32'h00000000, 3'b000, 3'b000, 5'd7, 2, 0, r, f);
    n_checks++;
    if (r !== 32'h7FC00000 || f !== 5'b10000) begin n_fail++; $display("FAIL invalid_mul: result=%h fflags=%b required 7fc00000 10000", r, f); end
  endtask

  task automatic test_rm();
    logic [31:0] r;
    logic [4:0] f;
    run_op(32'h40000000, 32'h40400000, 3'b111, 3'b001, 5'd9, 3, 0, r, f);
    n_checks++;
    if (m_rm !== 3'b001) begin n_fail++; $display("FAIL dyn_rm: mul_rm=%0d required 1", m_rm); end
    run_op(32'h12345678, 32'h9abcdef0, 3'b101, 3'b000, 5'd11, 2, 1, r, f);
    run_op(32'h0badf00d, 32'h3F800000, 3'b111, 3'b110, 5'd12, 2, 0, r, f);
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [4:0] f;
    run_op(32'h41200000, 32'hC0A00000, 3'b010, 3'b000, 5'd21, 7, 10, r, f);
  endtask

  task automatic test_flush_wait();
    int s0, cyc;
    bit saw;
    logic [31:0] r;
    logic [4:0] f;
    s0 = starts;
    send(32'h40490FDB, 32'h402DF854, 3'b011, 3'b000, 5'd4, 8);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || mul_a !== 32'h40490FDB || mul_rm !== 3'b011) begin
      n_fail++;
      $display("FAIL drain_enter: busy=%b valid=%b mul_a=%h rm=%0d required 1 0 40490fdb 3", busy, rsp_valid, mul_a, mul_rm);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_reflush: busy=%b required 1", busy); end
    wait_idle(cyc, saw);
    n_checks++;
    if (cyc >= 40 || saw || starts != s0 + 1 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wait: cycles=%0d saw_valid=%b starts=%0d mul_busy=%b required <40 0 1 0", cyc, saw, starts - s0, m_busy);
    end
    run_op(32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 5'd5, 6, 0, r, f);
    n_checks++;
    if (r !== 32'h3F800000) begin n_fail++; $display("FAIL after_flush: result=%h required 3f800000", r); end
  endtask

  task automatic test_flush_issue();
    int s0, cyc;
    bit saw;
    s0 = starts;
    send(32'h11111111, 32'h22222222, 3'b000, 3'b000, 5'd6, 4);
    n_checks++;
    if (mul_start !== 1'b1) begin n_fail++; $display("FAIL issue_pulse: start=%b required 1", mul_start); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(cyc, saw);
    n_checks++;
    if (cyc >= 40 || saw || starts != s0 + 1) begin
      n_fail++;
      $display("FAIL flush_issue: cycles=%0d saw_valid=%b starts=%0d required <40 0 1", cyc, saw, starts - s0);
    end
  endtask

  task automatic test_flush_done_same();
    send(32'h33333333, 32'h44444444, 3'b000, 3'b000, 5'd8, 2);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_done: busy=%b valid=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_flush_resp();
    int cnt = 0;
    send(32'h55555555, 32'h66666666, 3'b100, 3'b000, 5'd10, 2);
    while (rsp_valid !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (cnt >= 40 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_resp: cycles=%0d busy=%b valid=%b required <40 0 0", cnt, busy, rsp_valid);
    end
  endtask

  task automatic test_reset_wait();
    send(32'h77777777, 32'h88888888, 3'b010, 3'b000, 5'd13, 8);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_a !== 32'h0 || mul_rm !== 3'h0) begin
      n_fail++;
      $display("FAIL reset_wait: busy=%b valid=%b start=%b mul_a=%h rm=%0d required 0 0 0 0 0", busy, rsp_valid, mul_start, mul_a, mul_rm);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wait_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [4:0] f;
    for (int i = 0; i < 24; i++)
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), TAG_W'($urandom),
             int'($urandom_range(2, 9)), int'($urandom_range(0, 3)), r, f);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    frm = '0;
    req_rm = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_normal();
    test_invalid();
    test_rm();
    test_backpressure();
    test_flush_wait();
    test_flush_issue();
    test_flush_done_same();
    test_flush_resp();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_mul_seq.md
# fpu_mul_seq

Issue/collect sequencer directly upstream of `SP_Multiplier` in the FPU datapath. It accepts a multiply request from FP decode over a valid/ready handshake and resolves the dynamic rounding mode against `frm`. It pulses `start` to the multiplier and holds its operands stable until `done`. It then captures the result and flags as a RISC-V `fflags` vector and presents them to writeback over a second valid/ready handshake, with flush support.

## Interface
- `TAG_W`, default 5: width of the destination tag carried alongside the request.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline kill; discards the in-flight or pending operation.
- `frm` in 3: dynamic rounding mode from fcsr.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_a`, `req_b` in 32: IEEE-754 single-precision operands.
- `req_rm` in 3: instruction rm field; 3'b111 selects dynamic.
- `req_tag` in TAG_W: destination tag.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b` out 32, `mul_rm` out 3: multiplier operands and rounding mode.
- `mul_result` in 32: multiplier result.
- `mul_flag_invalid`, `mul_flag_overflow`, `mul_flag_underflow`, `mul_flag_inexact` in 1: multiplier exception flags.
- `mul_done` in 1: multiplier completion.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out 32: product.
- `rsp_fflags` out 5: {NV,DZ,OF,UF,NX}; DZ is always 0.
- `rsp_tag` out TAG_W: destination tag of the response.
- `rsp_illegal` out 1: illegal rounding mode.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- Reset sets state to IDLE and zeroes all registered outputs: `rsp_*`, `mul_a/b/rm`, `mul_start`.
- The multiplier's `rst_n` is tied to `~rst` in the parent.
- `req_ready` = (state==IDLE) && !flush.
- IDLE, on accept: latch a, b, tag, and resolved rm = (req_rm==3'b111) ? frm : req_rm.
  - Resolved rm in {101,110,111} → RESP with `rsp_illegal`=1, result 0, fflags 0. No start is issued.
  - Otherwise → ISSUE.
- ISSUE: `mul_start`=1 for exactly this cycle, then → WAIT.
- WAIT: `mul_a/b/rm` are held constant. The multiplier samples rm late, so rm must be stable until `mul_done`.
  - On `mul_done`=1, capture `mul_result` and the flags, then → RESP.
  - fflags = {inv,1'b0,ovf,unf,inx}.
- RESP: `rsp_valid`=1 and all `rsp_*` outputs are stable while stalled.
  - On `rsp_ready` → IDLE.
- Flush rules (flush has priority over every other transition):
  - IDLE: no effect.
  - RESP: response dropped → IDLE.
  - ISSUE or WAIT: the multiplier has no abort, so → DRAIN.
  - ISSUE+flush: the start pulse is still emitted this cycle.
  - DRAIN: `rsp_valid`=0. Wait for `mul_done`, discard the result → IDLE. Further flushes in DRAIN have no effect.
  - If `mul_done` and flush arrive in the same WAIT cycle → IDLE, result discarded.
- `mul_start` never asserts outside ISSUE. No new request is accepted before the previous `done`, so the multiplier is always in its WAITING state at start.

## Timing
- Accept on edge T. `mul_start` is high in cycle T+1. The multiplier samples start at the end of T+1.
- `mul_done` arrives no earlier than 2 cycles after start is sampled. Special-value paths take 2 cycles; normal paths take 6 or more, plus any denormal shifts.
- `rsp_valid` rises the cycle after `mul_done`.
- The illegal-rm response is valid in T+1.
- Throughput: at most one operation in flight. Minimum turnaround is accept → RESP (handshake) → IDLE (next accept). No back-to-back accepts.
- `rsp_valid` never drops without `rsp_ready` or `flush`.

## Structure
- Shared `fpu_pkg` holds:
  - rm encodings RNE/RTZ/RDN/RUP/RMM/DYN;
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0;
  - the state enum.
- One combinational sub-module, `fpu_rm_resolve` (req_rm, frm → rm, illegal), is reused by the adder and divider sequencers.
- `SP_Multiplier` is instantiated by the parent, not inside this block.

## Test plan
- Normal multiply: a=0x40000000, b=0x40400000, rm=000, tag=3. Required: one `mul_start` pulse, rsp_result=0x40C00000, fflags=0, rsp_tag=3.
- Invalid operation: 0x7F800000 × 0x00000000. Required: rsp_result=0x7FC00000, fflags=5'b10000.
- Dynamic and illegal rm:
  - req_rm=111 with frm=001 → `mul_rm`=001.
  - req_rm=101 → rsp_illegal=1 in T+1, fflags=0, no `mul_start`.
- Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp fields stable, req_ready=0, exactly one response on release.
- Flush during WAIT. Required: no rsp_valid, `mul_a/rm` held until `mul_done`, then IDLE. The next request 0x3F800000×0x3F800000 returns 0x3F800000.
- Reset asserted mid-WAIT. Required: the next cycle shows IDLE, rsp_valid=0, mul_start=0, busy=0.
